// File: rtl/dru_phase_ctrl_if.sv
// Window input and recovered-bit output bundle between the DRU and the phase controller.
// Optional phase override signals are present only with DRU_PHASE_OVERRIDE_EN defined.
interface dru_phase_ctrl_if;
  logic       in_valid;
  logic [7:0] sw;
  logic [3:0] edge_flags;
`ifdef DRU_PHASE_OVERRIDE_EN
  logic       ovr_en;
  logic [1:0] ovr_phase;
`endif
  logic [2:0] dout;
  logic [1:0] dout_cnt;
  logic       dout_valid;
  logic [1:0] phase;
  logic       locked;

`ifdef DRU_PHASE_OVERRIDE_EN
  modport master (
    output in_valid, sw, edge_flags, ovr_en, ovr_phase,
    input  dout, dout_cnt, dout_valid, phase, locked
  );
  modport slave (
    input  in_valid, sw, edge_flags, ovr_en, ovr_phase,
    output dout, dout_cnt, dout_valid, phase, locked
  );
`else
  modport master (
    output in_valid, sw, edge_flags,
    input  dout, dout_cnt, dout_valid, phase, locked
  );
  modport slave (
    input  in_valid, sw, edge_flags,
    output dout, dout_cnt, dout_valid, phase, locked
  );
`endif
endinterface

// File: rtl/dru_phase_ctrl.sv
// 4x-oversampling phase controller: votes on edge flags with hysteresis, emits 1-3 bits/window.
// Latency 1 cycle from in_valid; no backpressure. DRU_PHASE_OVERRIDE_EN adds a forced-phase input.
module dru_phase_ctrl #(
  parameter int unsigned VOTE_THRESH  = 4,
  parameter int unsigned LOCK_WINDOWS = 16,
  parameter int unsigned INIT_PHASE   = 0
) (
  input logic             clk,
  input logic             rst,
  dru_phase_ctrl_if.slave bus
);

  localparam logic [3:0] THRESH  = VOTE_THRESH[3:0];
  localparam logic [7:0] LOCK_W  = LOCK_WINDOWS[7:0];
  localparam logic [1:0] INIT_PH = INIT_PHASE[1:0];

  typedef enum logic {
    ST_ACQ,
    ST_LOCK
  } lock_st_e;

  lock_st_e   state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [1:0] prev_phase_q, prev_phase_d;
  logic       prev_sw7_q, prev_sw7_d;
  logic [3:0] vote_cnt_q, vote_cnt_d;
  logic [1:0] vote_tgt_q, vote_tgt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [2:0] dout_q, dout_d;
  logic [1:0] dout_cnt_q, dout_cnt_d;
  logic       dout_vld_q, dout_vld_d;

  logic       tgt_vld;
  logic [1:0] tgt;
  logic [3:0] cnt_upd;
  logic       step;
  logic       ovr_act;
  logic [1:0] ovr_phase_w;
  logic       smp_lo;
  logic       smp_hi;

`ifdef DRU_PHASE_OVERRIDE_EN
  assign ovr_act     = bus.ovr_en;
  assign ovr_phase_w = bus.ovr_phase;
`else
  assign ovr_act     = 1'b0;
  assign ovr_phase_w = 2'd0;
`endif

  // Edge region k implies the eye centre sits two phases away from it.
  always_comb begin
    tgt_vld = 1'b1;
    tgt     = 2'd0;
    case (bus.edge_flags)
      4'b0001: tgt = 2'd2;
      4'b0010: tgt = 2'd3;
      4'b0100: tgt = 2'd0;
      4'b1000: tgt = 2'd1;
      default: tgt_vld = 1'b0;
    endcase
  end

  assign smp_lo = bus.sw[{1'b0, phase_q}];
  assign smp_hi = bus.sw[{1'b1, phase_q}];

  always_comb begin
    phase_d    = phase_q;
    vote_cnt_d = vote_cnt_q;
    vote_tgt_d = vote_tgt_q;
    cnt_upd    = 4'd0;
    step       = 1'b0;
    if (bus.in_valid) begin
      if (ovr_act) begin
        phase_d    = ovr_phase_w;
        vote_cnt_d = 4'd0;
      end else if (!tgt_vld || (tgt == phase_q)) begin
        vote_cnt_d = 4'd0;
      end else begin
        if (tgt != vote_tgt_q) begin
          vote_tgt_d = tgt;
          cnt_upd    = 4'd1;
        end else if (vote_cnt_q >= THRESH) begin
          cnt_upd    = THRESH;
        end else begin
          cnt_upd    = vote_cnt_q + 4'd1;
        end
        vote_cnt_d = cnt_upd;
        if (cnt_upd == THRESH) begin
          step       = 1'b1;
          vote_cnt_d = 4'd0;
          // Targets one or two ahead both resolve as a forward step.
          if (tgt == (phase_q - 2'd1)) begin
            phase_d = phase_q - 2'd1;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (bus.in_valid) begin
      if (step || ovr_act) begin
        lock_cnt_d = 8'd0;
        state_d    = ST_ACQ;
      end else begin
        if (lock_cnt_q != 8'hFF) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
        case (state_q)
          ST_ACQ:  if (lock_cnt_d >= LOCK_W) state_d = ST_LOCK;
          ST_LOCK: state_d = ST_LOCK;
          default: state_d = ST_ACQ;
        endcase
      end
    end
  end

  // A wrap moves the sampling point across the window boundary, so one bit
  // is either duplicated (3->0, drop it) or skipped (0->3, recover it from prev_sw7).
  always_comb begin
    dout_d       = 3'd0;
    dout_cnt_d   = 2'd0;
    dout_vld_d   = bus.in_valid;
    prev_phase_d = prev_phase_q;
    prev_sw7_d   = prev_sw7_q;
    if (bus.in_valid) begin
      if ((prev_phase_q == 2'd3) && (phase_q == 2'd0)) begin
        dout_d     = {2'b00, bus.sw[4]};
        dout_cnt_d = 2'd1;
      end else if ((prev_phase_q == 2'd0) && (phase_q == 2'd3)) begin
        dout_d     = {bus.sw[7], bus.sw[3], prev_sw7_q};
        dout_cnt_d = 2'd3;
      end else begin
        dout_d     = {1'b0, smp_hi, smp_lo};
        dout_cnt_d = 2'd2;
      end
      prev_phase_d = phase_q;
      prev_sw7_d   = bus.sw[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACQ;
      phase_q      <= INIT_PH;
      prev_phase_q <= INIT_PH;
      prev_sw7_q   <= 1'b0;
      vote_cnt_q   <= 4'd0;
      vote_tgt_q   <= 2'd0;
      lock_cnt_q   <= 8'd0;
      dout_q       <= 3'd0;
      dout_cnt_q   <= 2'd0;
      dout_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_phase_q <= prev_phase_d;
      prev_sw7_q   <= prev_sw7_d;
      vote_cnt_q   <= vote_cnt_d;
      vote_tgt_q   <= vote_tgt_d;
      lock_cnt_q   <= lock_cnt_d;
      dout_q       <= dout_d;
      dout_cnt_q   <= dout_cnt_d;
      dout_vld_q   <= dout_vld_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_cnt   = dout_cnt_q;
  assign bus.dout_valid = dout_vld_q;
  assign bus.phase      = phase_q;
  assign bus.locked     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_dru_phase_ctrl.sv
// Randomised bench for dru_phase_ctrl against a queue-based behavioural model of the phase voter.
module tb_dru_phase_ctrl;

  localparam int VOTE_THRESH  = 4;
  localparam int LOCK_WINDOWS = 16;
  localparam int INIT_PHASE   = 0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dru_phase_ctrl_if bus ();

  dru_phase_ctrl #(
    .VOTE_THRESH (VOTE_THRESH),
    .LOCK_WINDOWS(LOCK_WINDOWS),
    .INIT_PHASE  (INIT_PHASE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: phase history, run of identical votes, windows since last step.
  int m_phase;
  int m_prev_phase;
  int m_prev_sw7;
  int m_run_q[$];
  int m_since_step;
  int exp_valid, exp_cnt, exp_dout, exp_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = INIT_PHASE;
    m_prev_phase = INIT_PHASE;
    m_prev_sw7   = 0;
    m_run_q.delete();
    m_since_step = 0;
    exp_valid    = 0;
    exp_cnt      = 0;
    exp_dout     = 0;
    exp_locked   = 0;
  endtask

  task automatic model_window(input logic v, input logic [7:0] s, input logic [3:0] e);
    int t, d, k;
    bit has_vote;
    bit stepped;
    exp_valid = v ? 1 : 0;
    exp_cnt   = 0;
    exp_dout  = 0;
    if (!v) return;
    if (m_prev_phase == 3 && m_phase == 0) begin
      exp_cnt  = 1;
      exp_dout = int'(s[4]);
    end else if (m_prev_phase == 0 && m_phase == 3) begin
      exp_cnt  = 3;
      exp_dout = m_prev_sw7 + 2 * int'(s[3]) + 4 * int'(s[7]);
    end else begin
      exp_cnt  = 2;
      exp_dout = int'(s[m_phase]) + 2 * int'(s[m_phase + 4]);
    end
    m_prev_phase = m_phase;
    m_prev_sw7   = int'(s[7]);

    has_vote = $onehot(e);
    t = 0;
    for (k = 0; k < 4; k++) if (e[k]) t = (k + 2) % 4;
    stepped = 1'b0;
    if (has_vote && t != m_phase) begin
      if (m_run_q.size() > 0 && m_run_q[0] != t) m_run_q.delete();
      m_run_q.push_back(t);
      if (m_run_q.size() == VOTE_THRESH) begin
        d = (t - m_phase + 4) % 4;
        m_phase = (d == 3) ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
        m_run_q.delete();
        stepped = 1'b1;
      end
    end else begin
      m_run_q.delete();
    end

    if (stepped) m_since_step = 0;
    else         m_since_step++;
    exp_locked = (m_since_step >= LOCK_WINDOWS) ? 1 : 0;
  endtask

  task automatic apply(input logic v, input logic [7:0] s, input logic [3:0] e);
    bus.in_valid   = v;
    bus.sw         = s;
    bus.edge_flags = e;
    @(posedge clk);
    #1;
    model_window(v, s, e);
    chk("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
    chk("dout_cnt",   32'(bus.dout_cnt),   32'(exp_cnt));
    chk("phase",      32'(bus.phase),      32'(m_phase));
    chk("locked",     32'(bus.locked),     32'(exp_locked));
    if (exp_valid != 0) chk("dout", 32'(bus.dout), 32'(exp_dout));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_dout_valid"}, 32'(bus.dout_valid), 32'(0));
    chk({tag, "_dout_cnt"},   32'(bus.dout_cnt),   32'(0));
    chk({tag, "_dout"},       32'(bus.dout),       32'(0));
    chk({tag, "_phase"},      32'(bus.phase),      32'(INIT_PHASE));
    chk({tag, "_locked"},     32'(bus.locked),     32'(0));
  endtask

  int         len, sel, tv;
  logic [3:0] e_r;
  logic [7:0] s_r;
  logic       v_r;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.sw         = 8'h00;
    bus.edge_flags = 4'h0;
`ifdef DRU_PHASE_OVERRIDE_EN
    bus.ovr_en     = 1'b0;
    bus.ovr_phase  = 2'd0;
`endif
    model_reset();
    #2;
    check_reset_state("rst_init");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // First window and lock acquisition.
    apply(1'b1, 8'b1111_0000, 4'b0000);
    chk("first_dout", 32'(bus.dout), 32'(3'b010));
    for (int i = 1; i < LOCK_WINDOWS - 1; i++) apply(1'b1, 8'(($urandom)), 4'b0000);
    chk("locked_before_16", 32'(bus.locked), 32'(0));
    apply(1'b1, 8'b1111_0000, 4'b0000);
    chk("locked_at_16", 32'(bus.locked), 32'(1));

    // Forward steps 0->1->2 from region 0 flags.
    for (int i = 0; i < 8; i++) apply(1'b1, 8'(($urandom)), 4'b0001);
    chk("phase_after_8", 32'(bus.phase), 32'(2));
    // 2->3, then 3->0 wrap and the dropped bit.
    for (int i = 0; i < 4; i++) apply(1'b1, 8'(($urandom)), 4'b0010);
    for (int i = 0; i < 4; i++) apply(1'b1, 8'(($urandom)), 4'b1000);
    chk("wrap30_phase", 32'(bus.phase), 32'(0));
    apply(1'b1, 8'h10, 4'b0000);
    chk("wrap30_cnt",  32'(bus.dout_cnt), 32'(1));
    chk("wrap30_dout", 32'(bus.dout),     32'(3'b001));
    // 0->3 backward wrap recovers the skipped bit.
    for (int i = 0; i < 3; i++) apply(1'b1, 8'(($urandom)), 4'b0010);
    apply(1'b1, 8'h80, 4'b0010);
    chk("wrap03_phase", 32'(bus.phase), 32'(3));
    apply(1'b1, 8'h88, 4'b0000);
    chk("wrap03_cnt",  32'(bus.dout_cnt), 32'(3));
    chk("wrap03_dout", 32'(bus.dout),     32'(3'b111));

    // Disagreeing votes, multi-hot flags and gaps never step.
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: e_r = 4'b0001;
        1: e_r = 4'b0010;
        2: e_r = 4'b0011;
        default: e_r = 4'b0001;
      endcase
      apply(1'b1, 8'(($urandom)), e_r);
      apply(1'b0, 8'(($urandom)), e_r);
    end
    chk("alt_phase_hold", 32'(bus.phase), 32'(3));

    // Randomised runs of held edge flags with valid gaps.
    for (int r = 0; r < 400; r++) begin
      len = $urandom_range(1, 8);
      sel = $urandom_range(0, 9);
      if (sel < 7)       e_r = 4'b0001 << $urandom_range(0, 3);
      else if (sel == 7) e_r = 4'b0000;
      else               e_r = 4'(($urandom));
      for (int k = 0; k < len; k++) begin
        v_r = ($urandom_range(0, 9) != 0);
        s_r = 8'(($urandom));
        apply(v_r, s_r, e_r);
      end
    end

    // Reset in the middle of a vote run.
    apply(1'b1, 8'(($urandom)), 4'b0000);
    tv  = (m_phase + 1) % 4;
    e_r = 4'b0001 << ((tv + 2) % 4);
    for (int i = 0; i < 3; i++) apply(1'b1, 8'(($urandom)), e_r);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    bus.in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(1'b1, 8'(($urandom)), 4'b0001);
    chk("post_rst_phase", 32'(bus.phase), 32'(INIT_PHASE));
    apply(1'b1, 8'(($urandom)), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
